uart_prog_loader: RTL

Downstream consumer of the UART receiver byte stream in the 8-bit CPU. It parses a framed program image (length byte, payload, checksum), writes the payload into a 2^ADDR_W x 8 instruction memory, and reports completion or error. In run mode it serves instruction bytes to the CPU at address `PC`.

---
 rtl/uart_prog_loader.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: parses a framed program image (length, payload,
// checksum) from the UART receiver into instruction memory, then serves
// instruction bytes to the CPU at PC while not loading.
//
// Ports:
//   Clk, Rst_n             clock, async active-low reset
//   Load                   loader-mode request (level)
//   rx_data/rx_valid/rx_fe byte stream from the UART receiver
//   PC                     instruction fetch address
//   instr                  registered instruction byte (NOP while busy)
//   Busy/Done/Err          loader status
//   Err_code               01 framing, 10 bad length, 11 checksum
//   Byte_cnt               payload bytes written in current/last load
module uart_prog_loader #(
    parameter int ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Load,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_fe,
    input  logic [ADDR_W-1:0] PC,
    output logic [7:0]        instr,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic [1:0]        Err_code,
    output logic [ADDR_W:0]   Byte_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [8:0] DEPTH9 = 9'(DEPTH);

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_FE   = 2'b01;
    localparam logic [1:0] CODE_LEN  = 2'b10;
    localparam logic [1:0] CODE_CSUM = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t state_q, state_d;

    logic              load_q;
    logic              load_rise;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [1:0]        code_q, code_d;
    logic [7:0]        instr_q, instr_d;
    logic [7:0]        mem_q [DEPTH];

    logic              mem_we;
    logic              len_bad;
    logic              busy;

    assign load_rise = Load && !load_q;
    assign len_bad   = (rx_data == 8'd0) || ({1'b0, rx_data} > DEPTH9);
    assign busy      = (state_q == S_LEN) || (state_q == S_DATA) ||
                       (state_q == S_CSUM);

    // State register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; dropping Load while loading wins over any strobe
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (load_rise) state_d = S_LEN;
            end
            S_LEN: begin
                if (!Load) begin
                    state_d = S_IDLE;
                end else if (rx_valid) begin
                    if (rx_fe || len_bad) state_d = S_ERR;
                    else state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (!Load) begin
                    state_d = S_IDLE;
                end else if (rx_valid) begin
                    if (rx_fe) state_d = S_ERR;
                    else if (rem_q == (ADDR_W+1)'(1)) state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (!Load) begin
                    state_d = S_IDLE;
                end else if (rx_valid) begin
                    if (!rx_fe && rx_data == csum_q) state_d = S_DONE;
                    else state_d = S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        Busy     = busy;
        Done     = (state_q == S_DONE);
        Err      = (state_q == S_ERR);
        Err_code = (state_q == S_ERR) ? code_q : CODE_NONE;
        Byte_cnt = cnt_q;
        instr    = instr_q;
    end

    // Datapath: address, counters, checksum, error cause, write enable
    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        cnt_d  = cnt_q;
        csum_d = csum_q;
        code_d = code_q;
        mem_we = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (load_rise) begin
                    addr_d = '0;
                    rem_d  = '0;
                    cnt_d  = '0;
                    csum_d = '0;
                    code_d = CODE_NONE;
                end
            end
            S_LEN: begin
                if (Load && rx_valid) begin
                    if (rx_fe) code_d = CODE_FE;
                    else if (len_bad) code_d = CODE_LEN;
                    else rem_d = rx_data[ADDR_W:0];
                end
            end
            S_DATA: begin
                if (Load && rx_valid) begin
                    if (rx_fe) begin
                        code_d = CODE_FE;
                    end else begin
                        mem_we = 1'b1;
                        // Wraps to 0 after a full-depth image; CSUM follows
                        addr_d = addr_q + ADDR_W'(1);
                        cnt_d  = cnt_q + (ADDR_W+1)'(1);
                        csum_d = csum_q + rx_data;
                        rem_d  = rem_q - (ADDR_W+1)'(1);
                    end
                end
            end
            S_CSUM: begin
                if (Load && rx_valid) begin
                    if (rx_fe) code_d = CODE_FE;
                    else if (rx_data != csum_q) code_d = CODE_CSUM;
                end
            end
            default: ;
        endcase
    end

    // Fetch path: NOP while a load is in progress
    always_comb begin
        instr_d = busy ? 8'h00 : mem_q[PC];
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            load_q  <= 1'b0;
            addr_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
            code_q  <= CODE_NONE;
            instr_q <= '0;
        end else begin
            load_q  <= Load;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            code_q  <= code_d;
            instr_q <= instr_d;
        end
    end

    // Memory is flop-based so reset can clear every entry
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (mem_we) begin
            mem_q[addr_q] <= rx_data;
        end
    end

endmodule
